lcd_hd44780_responder: RTL and testbench

Synthesizable HD44780-compatible responder: the display-side end of the rs/rw/en/dat LCD bus our controllers drive. It decodes the instruction subset used by our init and print sequences and keeps a 2x16 DDRAM image, address counter, display flags and busy flag. It supports bus reads of busy/AC and data. It serves as an on-FPGA loopback target and a simulation model for LCD controller blocks, and feeds a scan port for a debug/VGA mirror.

---
 rtl/lcd_pkg.sv | 55 +++++
 rtl/lcd_en_sync.sv | 54 +++++
 rtl/lcd_hd44780_responder.sv | 215 +++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, constants and address-counter helpers for the HD44780-style responder.
// The DDRAM image is 32 cells: line 1 at ac 0x00-0x0F, line 2 at ac 0x40-0x4F.
package lcd_pkg;

    typedef enum logic [1:0] {
        FILL,
        EXEC,
        IDLE
    } state_t;

    typedef struct packed {
        logic       en;
        logic       rs;
        logic       rw;
        logic [7:0] dat;
    } bus_t;

    localparam logic [7:0] BLANK       = 8'h20;
    localparam logic [6:0] LINE2_BASE  = 7'h40;
    localparam logic [6:0] LINE1_END   = 7'h27;
    localparam logic [6:0] LINE2_END   = 7'h67;
    localparam int         DDRAM_DEPTH = 32;

    localparam int BIT_ID     = 1;
    localparam int BIT_SH     = 0;
    localparam int BIT_DISP   = 2;
    localparam int BIT_CURSOR = 1;
    localparam int BIT_BLINK  = 0;
    localparam int BIT_SC     = 3;
    localparam int BIT_RL     = 2;

    // The two visible lines form one 80-position ring; other ac values wrap mod 128.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == LINE1_END)      r = LINE2_BASE;
            else if (a == LINE2_END) r = 7'h00;
            else                     r = a + 7'd1;
        end else begin
            if (a == 7'h00)            r = LINE2_END;
            else if (a == LINE2_BASE)  r = LINE1_END;
            else                       r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic ac_mapped(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] ac_index(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

endpackage

// File: rtl/lcd_en_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus, plus an alignment stage that
// provides en edge pulses and the rs/rw/dat values that were present while en was high.
module lcd_en_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] dat_in,
    output logic       en_sync,
    output logic       rs_sync,
    output logic       rw_sync,
    output logic       en_rise,
    output logic       en_fall,
    output logic       xfer_rs,
    output logic       xfer_rw,
    output logic [7:0] xfer_dat
);
    import lcd_pkg::*;

    bus_t s1_q, s1_d;
    bus_t s2_q, s2_d;
    bus_t s3_q, s3_d;

    always_comb begin
        s1_d = {en, rs, rw, dat_in};
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign en_sync  = s2_q.en;
    assign rs_sync  = s2_q.rs;
    assign rw_sync  = s2_q.rw;
    assign en_rise  = s2_q.en & ~s3_q.en;
    assign en_fall  = ~s2_q.en & s3_q.en;

    // On the fall cycle the third stage still holds the last sample taken with en high.
    assign xfer_rs  = s3_q.rs;
    assign xfer_rw  = s3_q.rw;
    assign xfer_dat = s3_q.dat;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Display-side HD44780 responder: decodes bus transactions, keeps the 2x16 DDRAM image,
// address counter, display flags and busy timing, and exposes a scan port for mirroring.
module lcd_hd44780_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    input  logic [7:0] dat_in,
    output logic [7:0] dat_out,
    output logic       dat_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       ovr,
    input  logic [4:0] scan_addr,
    output logic [7:0] scan_char
);
    import lcd_pkg::*;

    localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES);
    localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES);
    localparam logic [4:0]  FILL_LAST  = 5'(DDRAM_DEPTH - 1);

    logic       en_sync, rs_sync, rw_sync, en_rise, en_fall;
    logic       xfer_rs, xfer_rw;
    logic [7:0] xfer_dat;

    lcd_en_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .rs       (rs),
        .rw       (rw),
        .dat_in   (dat_in),
        .en_sync  (en_sync),
        .rs_sync  (rs_sync),
        .rw_sync  (rw_sync),
        .en_rise  (en_rise),
        .en_fall  (en_fall),
        .xfer_rs  (xfer_rs),
        .xfer_rw  (xfer_rw),
        .xfer_dat (xfer_dat)
    );

    state_t      state_q, state_d;
    logic [4:0]  fill_idx_q, fill_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  ac_q, ac_d;
    logic        id_q, id_d;
    logic        sh_q, sh_d;
    logic        disp_q, disp_d;
    logic        cursor_q, cursor_d;
    logic        blink_q, blink_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  dat_out_q, dat_out_d;
    logic        dat_oe_q, dat_oe_d;
    logic [7:0]  scan_char_q, scan_char_d;

    logic [7:0]  ddram_q [DDRAM_DEPTH];
    logic        mem_we;
    logic [4:0]  mem_idx;
    logic [7:0]  mem_wdata;
    logic [7:0]  read_char;

    assign busy      = (state_q != IDLE);
    assign read_char = ac_mapped(ac_q) ? ddram_q[ac_index(ac_q)] : BLANK;

    always_comb begin
        state_d     = state_q;
        fill_idx_d  = fill_idx_q;
        cnt_d       = cnt_q;
        ac_d        = ac_q;
        id_d        = id_q;
        sh_d        = sh_q;
        disp_d      = disp_q;
        cursor_d    = cursor_q;
        blink_d     = blink_q;
        ovr_d       = ovr_q;
        dat_out_d   = dat_out_q;
        dat_oe_d    = dat_oe_q;
        mem_we      = 1'b0;
        mem_idx     = fill_idx_q;
        mem_wdata   = BLANK;
        scan_char_d = ddram_q[scan_addr];

        // Read data tracks the live state for as long as the controller holds en high.
        if (en_rise) dat_oe_d = rw_sync;
        if (!en_sync) dat_oe_d = 1'b0;
        if (en_sync && rw_sync) begin
            if (rs_sync) dat_out_d = (state_q == IDLE) ? read_char : 8'h00;
            else         dat_out_d = {busy, ac_q};
        end

        unique case (state_q)
            FILL: begin
                mem_we     = 1'b1;
                fill_idx_d = fill_idx_q + 5'd1;
                if (fill_idx_q == FILL_LAST) begin
                    state_d = EXEC;
                    cnt_d   = CLEAR_LOAD;
                end
            end
            EXEC: begin
                if (cnt_q <= 16'd1) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            IDLE: begin
                if (en_fall) begin
                    if (xfer_rw) begin
                        if (xfer_rs) ac_d = ac_step(ac_q, id_q);
                    end else if (xfer_rs) begin
                        mem_we    = ac_mapped(ac_q);
                        mem_idx   = ac_index(ac_q);
                        mem_wdata = xfer_dat;
                        ac_d      = ac_step(ac_q, id_q);
                        state_d   = EXEC;
                        cnt_d     = BUSY_LOAD;
                    end else begin
                        state_d = EXEC;
                        cnt_d   = BUSY_LOAD;
                        // The highest set bit selects the instruction.
                        casez (xfer_dat)
                            8'b1???????: ac_d = xfer_dat[6:0];
                            8'b01??????, 8'b001?????: begin
                            end
                            8'b0001????: begin
                                if (!xfer_dat[BIT_SC]) ac_d = ac_step(ac_q, xfer_dat[BIT_RL]);
                            end
                            8'b00001???: begin
                                disp_d   = xfer_dat[BIT_DISP];
                                cursor_d = xfer_dat[BIT_CURSOR];
                                blink_d  = xfer_dat[BIT_BLINK];
                            end
                            8'b000001??: begin
                                id_d = xfer_dat[BIT_ID];
                                sh_d = xfer_dat[BIT_SH];
                            end
                            8'b0000001?: begin
                                ac_d  = 7'h00;
                                cnt_d = CLEAR_LOAD;
                            end
                            8'b00000001: begin
                                ac_d       = 7'h00;
                                id_d       = 1'b1;
                                state_d    = FILL;
                                fill_idx_d = 5'd0;
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // Status reads are always allowed; anything else while busy is rejected and remembered.
        if (en_fall && busy && (xfer_rs || !xfer_rw)) ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            fill_idx_q <= 5'd0;
            cnt_q      <= 16'd0;
            ac_q       <= 7'h00;
            id_q       <= 1'b1;
            sh_q       <= 1'b0;
            disp_q     <= 1'b0;
            cursor_q   <= 1'b0;
            blink_q    <= 1'b0;
            ovr_q      <= 1'b0;
            dat_out_q  <= 8'h00;
            dat_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_idx_q <= fill_idx_d;
            cnt_q      <= cnt_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            sh_q       <= sh_d;
            disp_q     <= disp_d;
            cursor_q   <= cursor_d;
            blink_q    <= blink_d;
            ovr_q      <= ovr_d;
            dat_out_q  <= dat_out_d;
            dat_oe_q   <= dat_oe_d;
        end
    end

    // DDRAM has no reset of its own; the FILL phase after reset blanks it.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) ddram_q[mem_idx] <= mem_wdata;
        scan_char_q <= scan_char_d;
    end

    assign dat_out   = dat_out_q;
    assign dat_oe    = dat_oe_q;
    assign ac        = ac_q;
    assign disp_on   = disp_q;
    assign cursor_on = cursor_q;
    assign blink_on  = blink_q;
    assign ovr       = ovr_q;
    assign scan_char = scan_char_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder: directed scenarios plus randomized
// transactions compared against a behavioural model of the display.
module tb_lcd_hd44780_responder;

    localparam int BUSY_CYCLES  = 40;
    localparam int CLEAR_CYCLES = 1600;

    logic       clk = 1'b0;
    logic       reset;
    logic       rs, rw, en;
    logic [7:0] dat_in;
    logic [7:0] dat_out;
    logic       dat_oe, busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, ovr;
    logic [4:0] scan_addr;
    logic [7:0] scan_char;

    lcd_hd44780_responder #(
        .BUSY_CYCLES  (BUSY_CYCLES),
        .CLEAR_CYCLES (CLEAR_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rs        (rs),
        .rw        (rw),
        .en        (en),
        .dat_in    (dat_in),
        .dat_out   (dat_out),
        .dat_oe    (dat_oe),
        .busy      (busy),
        .ac        (ac),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .ovr       (ovr),
        .scan_addr (scan_addr),
        .scan_char (scan_char)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    // Behavioural display model: DDRAM image, address counter and flags.
    logic [7:0] m_mem [32];
    logic [6:0] m_ac;
    logic       m_id, m_disp, m_cur, m_blink, m_ovr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    endtask

    // The visible addresses form an 80-position ring (40 per line); others wrap mod 128.
    function automatic logic [6:0] modelStep(input logic [6:0] a, input logic inc);
        int p;
        if (a <= 7'h27) p = int'(a);
        else if (a >= 7'h40 && a <= 7'h67) p = int'(a) - 'h40 + 40;
        else p = -1;
        if (p < 0) return inc ? a + 7'd1 : a - 7'd1;
        p = inc ? (p + 1) % 80 : (p + 79) % 80;
        return (p < 40) ? 7'(p) : 7'(p - 40 + 'h40);
    endfunction

    function automatic int modelIdx(input logic [6:0] a);
        if (a <= 7'h0F) return int'(a);
        if (a >= 7'h40 && a <= 7'h4F) return int'(a) - 'h40 + 16;
        return -1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_ac = 7'h00; m_id = 1'b1; m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic modelApply(input logic r_s, input logic r_w, input logic [7:0] d, input bit is_busy,
                              output int exp_busy, output logic [7:0] exp_read);
        int idx;
        exp_busy = 0;
        exp_read = 8'h00;
        if (is_busy) begin
            if (r_s || !r_w) m_ovr = 1'b1;
            if (!r_s) exp_read = {1'b1, m_ac};
        end else if (r_w) begin
            if (!r_s) exp_read = {1'b0, m_ac};
            else begin
                idx = modelIdx(m_ac);
                exp_read = (idx >= 0) ? m_mem[idx] : 8'h20;
                m_ac = modelStep(m_ac, m_id);
            end
        end else if (r_s) begin
            idx = modelIdx(m_ac);
            if (idx >= 0) m_mem[idx] = d;
            m_ac = modelStep(m_ac, m_id);
            exp_busy = BUSY_CYCLES;
        end else begin
            exp_busy = BUSY_CYCLES;
            if (d >= 8'h80) m_ac = d[6:0];
            else if (d >= 8'h20) exp_busy = BUSY_CYCLES;
            else if (d >= 8'h10) begin
                if (!d[3]) m_ac = modelStep(m_ac, d[2]);
            end else if (d >= 8'h08) {m_disp, m_cur, m_blink} = d[2:0];
            else if (d >= 8'h04) m_id = d[1];
            else if (d >= 8'h02) begin
                m_ac = 7'h00;
                exp_busy = CLEAR_CYCLES;
            end else if (d == 8'h01) begin
                for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
                m_ac = 7'h00;
                m_id = 1'b1;
                exp_busy = 32 + CLEAR_CYCLES;
            end else exp_busy = 0;
        end
    endtask

    // One bus cycle: en high for 5 clocks (read data sampled at the end), then low with data held.
    task automatic busCycle(input logic r_s, input logic r_w, input logic [7:0] d,
                            output logic [7:0] rd, output logic oe);
        rs = r_s; rw = r_w; dat_in = d; en = 1'b1;
        repeat (5) @(negedge clk);
        rd = dat_out;
        oe = dat_oe;
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic r_s, input logic r_w, input logic [7:0] d, input string tag);
        logic [7:0] rd, exp_read;
        logic       oe;
        int         exp_busy, n;
        busCycle(r_s, r_w, d, rd, oe);
        modelApply(r_s, r_w, d, 1'b0, exp_busy, exp_read);
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        checkOutput({tag, ".busyLen"}, n, exp_busy);
        if (r_w) begin
            checkOutput({tag, ".oe"}, oe, 1);
            checkOutput({tag, ".rd"}, rd, exp_read);
        end
        checkOutput({tag, ".ac"}, ac, m_ac);
        checkOutput({tag, ".flags"}, {disp_on, cursor_on, blink_on}, {m_disp, m_cur, m_blink});
        checkOutput({tag, ".ovr"}, ovr, m_ovr);
    endtask

    task automatic applyNoWait(input logic r_s, input logic r_w, input logic [7:0] d, input bit is_busy,
                               output logic [7:0] rd, output logic oe, output logic [7:0] exp_read);
        int exp_busy;
        busCycle(r_s, r_w, d, rd, oe);
        modelApply(r_s, r_w, d, is_busy, exp_busy, exp_read);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, ".idle"}, busy, 0);
    endtask

    task automatic readScan(input int idx, output logic [7:0] v);
        scan_addr = 5'(idx);
        @(negedge clk);
        v = scan_char;
    endtask

    task automatic checkScanAll(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            readScan(i, v);
            checkOutput($sformatf("%s[%0d]", tag, i), v, m_mem[i]);
        end
    endtask

    function automatic logic [7:0] boundaryAddr(input int k);
        case (k)
            0: return 8'h80;  1: return 8'h8E;  2: return 8'h8F;  3: return 8'h90;
            4: return 8'hA6;  5: return 8'hA7;  6: return 8'hBF;  7: return 8'hC0;
            8: return 8'hCE;  9: return 8'hCF;  10: return 8'hD0; 11: return 8'hE6;
            12: return 8'hE7; default: return 8'h80 | 8'($urandom_range(0, 127));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] v, rd, exp_read, r;
        logic       oe;
        int         n, sel;

        reset = 1'b1; en = 1'b0; rs = 1'b0; rw = 1'b0; dat_in = 8'h00; scan_addr = 5'd0;
        repeat (4) @(negedge clk);
        checkOutput("reset.busy", busy, 1);
        checkOutput("reset.dat_oe", dat_oe, 0);
        checkOutput("reset.dat_out", dat_out, 0);

        $display("[TB] power-up fill and clear timing");
        modelReset();
        reset = 1'b0;
        checkOutput("reset.ac", ac, 0);
        checkOutput("reset.ovr", ovr, 0);
        checkOutput("reset.flags", {disp_on, cursor_on, blink_on}, 0);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        checkOutput("powerup.busyLen", n, 32 + CLEAR_CYCLES);
        checkScanAll("powerup.scan");

        $display("[TB] basic init and print");
        applyStimulus(1'b0, 1'b0, 8'h06, "cmd06");
        applyStimulus(1'b0, 1'b0, 8'h0C, "cmd0C");
        applyStimulus(1'b1, 1'b0, 8'h41, "dataA");
        applyStimulus(1'b1, 1'b0, 8'h42, "dataB");
        checkOutput("init.disp_on", disp_on, 1);
        checkOutput("init.cursor_on", cursor_on, 0);
        readScan(0, v); checkOutput("init.scan0", v, 8'h41);
        readScan(1, v); checkOutput("init.scan1", v, 8'h42);
        checkOutput("init.ac", ac, 7'h02);

        $display("[TB] line wrap and decrement");
        applyStimulus(1'b0, 1'b0, 8'hA7, "setAc27");
        checkOutput("wrap.ac27", ac, 7'h27);
        applyStimulus(1'b1, 1'b0, 8'h58, "data58");
        checkOutput("wrap.ac40", ac, 7'h40);
        applyStimulus(1'b1, 1'b0, 8'h59, "data59");
        readScan(16, v); checkOutput("wrap.scan16", v, 8'h59);
        checkOutput("wrap.ac41", ac, 7'h41);
        applyStimulus(1'b0, 1'b0, 8'h80, "setAc00");
        applyStimulus(1'b0, 1'b0, 8'h04, "cmd04");
        applyStimulus(1'b1, 1'b0, 8'h5A, "data5A");
        readScan(0, v); checkOutput("dec.scan0", v, 8'h5A);
        checkOutput("dec.ac67", ac, 7'h67);
        applyStimulus(1'b0, 1'b0, 8'h80, "setAc00b");
        applyStimulus(1'b1, 1'b1, 8'h00, "readData0");
        checkOutput("dec.readAc", ac, 7'h67);
        applyStimulus(1'b0, 1'b0, 8'h06, "cmd06b");
        checkScanAll("wrap.scan");

        $display("[TB] status read while busy and overrun");
        applyStimulus(1'b0, 1'b0, 8'h85, "setAc05");
        applyNoWait(1'b1, 1'b0, 8'h43, 1'b0, rd, oe, exp_read);
        repeat (8) @(negedge clk);
        applyNoWait(1'b0, 1'b1, 8'h00, 1'b1, rd, oe, exp_read);
        checkOutput("busyStatus.rd", rd, 8'h86);
        checkOutput("busyStatus.rdModel", rd, exp_read);
        checkOutput("busyStatus.oe", oe, 1);
        applyNoWait(1'b1, 1'b0, 8'h33, 1'b1, rd, oe, exp_read);
        waitIdle("ovr");
        checkOutput("ovr.set", ovr, 1);
        checkOutput("ovr.ac", ac, 7'h06);
        readScan(6, v); checkOutput("ovr.scan6", v, 8'h20);
        readScan(5, v); checkOutput("ovr.scan5", v, 8'h43);
        applyStimulus(1'b0, 1'b1, 8'h00, "idleStatus");
        checkOutput("idleStatus.oeOff", dat_oe, 0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 99);
            r = 8'($urandom);
            if (sel < 30)      applyStimulus(1'b1, 1'b0, r, "rndWrite");
            else if (sel < 42) applyStimulus(1'b1, 1'b1, 8'h00, "rndRead");
            else if (sel < 48) applyStimulus(1'b0, 1'b1, 8'h00, "rndStatus");
            else if (sel < 58) applyStimulus(1'b0, 1'b0, boundaryAddr($urandom_range(0, 14)), "rndSetAc");
            else if (sel < 66) applyStimulus(1'b0, 1'b0, 8'h04 | (r & 8'h03), "rndEntry");
            else if (sel < 74) applyStimulus(1'b0, 1'b0, 8'h08 | (r & 8'h07), "rndDisp");
            else if (sel < 84) applyStimulus(1'b0, 1'b0, 8'h10 | (r & 8'h0F), "rndShift");
            else if (sel < 88) applyStimulus(1'b0, 1'b0, 8'h20 | (r & 8'h1F), "rndFunc");
            else if (sel < 92) applyStimulus(1'b0, 1'b0, 8'h40 | (r & 8'h3F), "rndCgram");
            else if (sel < 95) applyStimulus(1'b0, 1'b0, 8'h00, "rndNop");
            else if (sel < 98) applyStimulus(1'b0, 1'b0, 8'h02 | (r & 8'h01), "rndHome");
            else               applyStimulus(1'b0, 1'b0, 8'h01, "rndClear");
        end
        checkOutput("rnd.ovrSticky", ovr, 1);
        checkScanAll("rnd.scan");

        $display("[TB] reset during clear fill");
        applyNoWait(1'b0, 1'b0, 8'h01, 1'b0, rd, oe, exp_read);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        modelReset();
        reset = 1'b0;
        checkOutput("rst2.ovr", ovr, 0);
        checkOutput("rst2.ac", ac, 0);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        checkOutput("rst2.busyLen", n, 32 + CLEAR_CYCLES);
        checkScanAll("rst2.scan");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
